// File: rtl/edge_sign_collector.sv
// edge_sign_collector
// Collects edge-function values (AB, BC, CA) in groups of three, one group
// per pixel, and classifies each pixel as inside or outside the triangle.
// Results carry raster coordinates from internal x/y counters, a saturating
// per-triangle inside count, and a pulse on the last pixel of the raster.
module edge_sign_collector #(
  parameter int SYS_BIT_WIDTH = 6,
  parameter int RASTER_W      = 64,
  parameter int RASTER_H      = 64,
  parameter int INCLUDE_EDGE  = 1,
  localparam int VW = 2 * SYS_BIT_WIDTH + 1,
  localparam int XW = (RASTER_W > 1) ? $clog2(RASTER_W) : 1,
  localparam int YW = (RASTER_H > 1) ? $clog2(RASTER_H) : 1,
  localparam int CW = $clog2(RASTER_W * RASTER_H) + 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tri_start_in,
  input  logic                 orient_in,
  input  logic                 degen_in,
  input  logic                 valid_in,
  input  logic signed [VW-1:0] value_in,
  output logic                 valid_out,
  output logic                 inside_out,
  output logic [XW-1:0]        pixel_x_out,
  output logic [YW-1:0]        pixel_y_out,
  output logic                 frame_done_out,
  output logic [CW-1:0]        inside_count_out
);

  typedef enum logic [1:0] {
    E0 = 2'd0,
    E1 = 2'd1,
    E2 = 2'd2
  } edge_state_t;

  edge_state_t state_q, state_d;
  logic        and_q, and_d;       // running AND of inside_edge within a group
  logic        orient_q;
  logic        degen_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] count_q;

  logic          orient_eff;
  logic          inside_edge;
  logic          emit;
  logic          pixel_inside;
  logic          last_x;
  logic          last_y;
  logic [CW-1:0] count_next;

  // Edge-counter state register: reset and tri_start both restart the group.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    if (rst_in) begin
      state_q <= E0;
      and_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      and_q   <= and_d;
    end
  end

  // Next-state logic: edge classification, group accumulation, emit decision.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    and_d        = and_q;
    emit         = 1'b0;
    count_next   = count_q;

    // A coincident tri_start classifies its value with the incoming winding.
    orient_eff = tri_start_in ? orient_in : orient_q;

    if (value_in == '0) begin
      inside_edge = (INCLUDE_EDGE != 0);
    end else if (orient_eff) begin
      inside_edge = value_in[VW-1];
    end else begin
      inside_edge = ~value_in[VW-1];
    end

    pixel_inside = and_q & inside_edge & ~degen_q;
    last_x       = (x_q == XW'(RASTER_W - 1));
    last_y       = (y_q == YW'(RASTER_H - 1));

    if (tri_start_in) begin
      // The value arriving with tri_start becomes edge AB of pixel (0,0);
      // any partial group of the previous triangle is dropped.
      if (valid_in) begin
        state_d = E1;
        and_d   = inside_edge;
      end else begin
        state_d = E0;
        and_d   = 1'b1;
      end
    end else if (valid_in) begin
      case (state_q)
        E0: begin
          state_d = E1;
          and_d   = inside_edge;
        end
        E1: begin
          state_d = E2;
          and_d   = and_q & inside_edge;
        end
        E2: begin
          state_d = E0;
          and_d   = 1'b1;
          emit    = 1'b1;
        end
        default: begin
          state_d = E0;
          and_d   = 1'b1;
        end
      endcase
    end

    if (emit && pixel_inside && (count_q != '1)) begin
      count_next = count_q + CW'(1);
    end
  end

  // Per-triangle latches, raster counters, inside count and registered results.
  always_ff @(posedge clk_in) begin
    // NOTE: only control and output registers need reset; there is no
    // memory array here, so everything that holds state is cleared.
    if (rst_in) begin
      orient_q         <= 1'b0;
      degen_q          <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      count_q          <= '0;
      valid_out        <= 1'b0;
      inside_out       <= 1'b0;
      pixel_x_out      <= '0;
      pixel_y_out      <= '0;
      frame_done_out   <= 1'b0;
      inside_count_out <= '0;
    end else begin
      valid_out      <= emit;
      frame_done_out <= emit && last_x && last_y;

      if (tri_start_in) begin
        orient_q <= orient_in;
        degen_q  <= degen_in;
        x_q      <= '0;
        y_q      <= '0;
        count_q  <= '0;
      end else if (emit) begin
        inside_out       <= pixel_inside;
        pixel_x_out      <= x_q;
        pixel_y_out      <= y_q;
        inside_count_out <= count_next;
        count_q          <= count_next;

        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_sign_collector.sv
// Self-checking bench for edge_sign_collector on a 4x2 raster.
// A second instance with zero edges counted as outside shares the stimulus.
module tb_edge_sign_collector;

  localparam int SW = 6;
  localparam int VW = 2 * SW + 1;
  localparam int RW = 4;
  localparam int RH = 2;
  localparam int XW = $clog2(RW);
  localparam int YW = $clog2(RH);
  localparam int CW = $clog2(RW * RH) + 1;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic ins;    // inside_out with zero edges inside
    logic ins0;   // inside_out with zero edges outside
    int   x;
    int   y;
    logic fd;
    int   cnt;
  } exp_t;

  typedef struct {
    logic                 start;
    logic                 orient;
    logic                 degen;
    logic signed [VW-1:0] v0;
    logic signed [VW-1:0] v1;
    logic signed [VW-1:0] v2;
    int                   gap;
    exp_t                 e;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_in;
  logic                 tri_start_in;
  logic                 orient_in;
  logic                 degen_in;
  logic                 valid_in;
  logic signed [VW-1:0] value_in;

  logic          valid_out, inside_out, frame_done_out;
  logic [XW-1:0] pixel_x_out;
  logic [YW-1:0] pixel_y_out;
  logic [CW-1:0] inside_count_out;

  logic          valid_out2, inside_out2, frame_done_out2;
  logic [XW-1:0] pixel_x_out2;
  logic [YW-1:0] pixel_y_out2;
  logic [CW-1:0] inside_count_out2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  edge_sign_collector #(
    .SYS_BIT_WIDTH(SW), .RASTER_W(RW), .RASTER_H(RH), .INCLUDE_EDGE(1)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .tri_start_in(tri_start_in),
    .orient_in(orient_in), .degen_in(degen_in), .valid_in(valid_in),
    .value_in(value_in), .valid_out(valid_out), .inside_out(inside_out),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .frame_done_out(frame_done_out), .inside_count_out(inside_count_out)
  );

  edge_sign_collector #(
    .SYS_BIT_WIDTH(SW), .RASTER_W(RW), .RASTER_H(RH), .INCLUDE_EDGE(0)
  ) dut_noedge (
    .clk_in(clk), .rst_in(rst_in), .tri_start_in(tri_start_in),
    .orient_in(orient_in), .degen_in(degen_in), .valid_in(valid_in),
    .value_in(value_in), .valid_out(valid_out2), .inside_out(inside_out2),
    .pixel_x_out(pixel_x_out2), .pixel_y_out(pixel_y_out2),
    .frame_done_out(frame_done_out2), .inside_count_out(inside_count_out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mke(input int ins, input int ins0, input int x,
                               input int y, input int fd, input int cnt);
    exp_t e;
    e.ins  = ins[0];
    e.ins0 = ins0[0];
    e.x    = x;
    e.y    = y;
    e.fd   = fd[0];
    e.cnt  = cnt;
    return e;
  endfunction

  function automatic vec_t mkv(input int st, input int o, input int d,
                               input int a, input int b, input int c,
                               input int gap, input exp_t e);
    vec_t v;
    v.start  = st[0];
    v.orient = o[0];
    v.degen  = d[0];
    v.v0     = VW'(a);
    v.v1     = VW'(b);
    v.v2     = VW'(c);
    v.gap    = gap;
    v.e      = e;
    return v;
  endfunction

  // Drive one value for one edge, then idle for gap cycles.
  task automatic send(input logic signed [VW-1:0] v, input int gap);
    valid_in = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_tri(input logic o, input logic d);
    tri_start_in = 1'b1;
    orient_in    = o;
    degen_in     = d;
    @(posedge clk);
    #1;
    tri_start_in = 1'b0;
  endtask

  task automatic group(input logic signed [VW-1:0] a, input logic signed [VW-1:0] b,
                       input logic signed [VW-1:0] c, input int gap, input exp_t e);
    sb.push_back(e);
    send(a, gap);
    send(b, gap);
    send(c, gap);
  endtask

  // Scoreboard: every result pulse pops one expectation.
  always @(negedge clk) begin
    if (valid_out === 1'b1 || valid_out2 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_out",        32'(valid_out),        32'd1);
        check("valid_out_noedge", 32'(valid_out2),       32'd1);
        check("inside_out",       32'(inside_out),       32'(e.ins));
        check("inside_out_noedge",32'(inside_out2),      32'(e.ins0));
        check("pixel_x_out",      32'(pixel_x_out),      e.x);
        check("pixel_y_out",      32'(pixel_y_out),      e.y);
        check("frame_done_out",   32'(frame_done_out),   32'(e.fd));
        check("inside_count_out", 32'(inside_count_out), e.cnt);
      end
    end else if (frame_done_out === 1'b1) begin
      check("frame_done_without_valid", 32'(frame_done_out), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ins, ins0, x, y, fd, cnt on a 4x2 raster
    vecs.push_back(mkv(1, 0, 0,     5,   7,  1, 0, mke(1, 1, 0, 0, 0, 1)));
    vecs.push_back(mkv(0, 0, 0,     5,  -3,  1, 1, mke(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mkv(1, 1, 0,  -600, -12, -1, 0, mke(1, 1, 0, 0, 0, 1)));
    vecs.push_back(mkv(0, 1, 0, -4096,  -1, -2, 0, mke(1, 1, 1, 0, 0, 2)));
    vecs.push_back(mkv(0, 1, 0,  4095,  -1, -1, 0, mke(0, 0, 2, 0, 0, 2)));
    vecs.push_back(mkv(1, 1, 0,     0,  -4, -4, 0, mke(1, 0, 0, 0, 0, 1)));
    vecs.push_back(mkv(1, 0, 0,     0,   4,  4, 0, mke(1, 0, 0, 0, 0, 1)));
    vecs.push_back(mkv(0, 0, 0,     4,   0,  4, 2, mke(1, 0, 1, 0, 0, 2)));
    vecs.push_back(mkv(1, 0, 1,     1,   1,  1, 0, mke(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, 0, 1,     0,   0,  0, 0, mke(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mkv(1, 0, 0,     1,   1,  1, 0, mke(1, 1, 0, 0, 0, 1)));
    vecs.push_back(mkv(0, 0, 0,    -1,   1,  1, 0, mke(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mkv(0, 0, 0,     2,   2,  2, 0, mke(1, 1, 2, 0, 0, 2)));
    vecs.push_back(mkv(0, 0, 0,     3,   3,  3, 0, mke(1, 1, 3, 0, 0, 3)));

    rst_in       = 1'b1;
    tri_start_in = 1'b0;
    orient_in    = 1'b0;
    degen_in     = 1'b0;
    valid_in     = 1'b0;
    value_in     = '0;

    // Reset with valid_in toggling: outputs cleared, no result afterwards.
    for (int i = 0; i < 2; i++) begin
      valid_in = (i == 0);
      value_in = VW'(1);
      @(posedge clk);
      @(negedge clk);
      check("rst_valid_out",        32'(valid_out),        32'd0);
      check("rst_inside_out",       32'(inside_out),       32'd0);
      check("rst_pixel_x_out",      32'(pixel_x_out),      32'd0);
      check("rst_pixel_y_out",      32'(pixel_y_out),      32'd0);
      check("rst_frame_done_out",   32'(frame_done_out),   32'd0);
      check("rst_inside_count_out", 32'(inside_count_out), 32'd0);
    end
    rst_in   = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_valid_out", 32'(valid_out), 32'd0);

    // Table-driven groups.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].start) start_tri(vecs[i].orient, vecs[i].degen);
      group(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].gap, vecs[i].e);
    end

    // Raster wrap and count saturation, with idle gaps between values.
    start_tri(1'b0, 1'b0);
    for (int k = 0; k < 18; k++) begin
      int c;
      c = (k + 1 > CMAX) ? CMAX : k + 1;
      group(VW'(k + 1), VW'(k + 1), VW'(k + 1), 2,
            mke(1, 1, k % RW, (k / RW) % RH, ((k % (RW * RH)) == RW * RH - 1) ? 1 : 0, c));
    end

    // tri_start coincident with the third value of a pending group.
    send(VW'(1), 0);
    send(VW'(1), 0);
    sb.push_back(mke(1, 1, 0, 0, 0, 1));
    tri_start_in = 1'b1;
    orient_in    = 1'b0;
    degen_in     = 1'b0;
    send(VW'(9), 0);
    tri_start_in = 1'b0;
    send(VW'(2), 0);
    send(VW'(3), 1);

    // Same corner, coincident value classified with the new negative winding.
    send(VW'(1), 0);
    send(VW'(1), 0);
    sb.push_back(mke(1, 1, 0, 0, 0, 1));
    tri_start_in = 1'b1;
    orient_in    = 1'b1;
    send(-VW'(9), 0);
    tri_start_in = 1'b0;
    send(-VW'(2), 0);
    send(-VW'(3), 1);

    // Reset mid-group (with a value on the reset edge) drops the group.
    send(VW'(1), 0);
    send(VW'(1), 0);
    rst_in = 1'b1;
    send(VW'(1), 0);
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_mid_group_valid_out", 32'(valid_out), 32'd0);
    group(VW'(1), VW'(1), VW'(1), 0, mke(1, 1, 0, 0, 0, 1));

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pending_results", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
